mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 95 +++++++++
 tb/tb_mem_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between an instruction-cache and a data-cache requester
// Ports: clk, reset (async, active-high)
//   i_req, i_addr -> i_rdata, i_valid, i_done            instruction line-fill port
//   d_rd, d_wr, d_addr, d_wdata -> d_rdata, d_valid, d_done   data fill / write-through port
//   mem_read, mem_write, mem_addr, mem_wdata -> memory; mem_rdata, mem_ready <- memory
// Option: define MEM_ARBITER_RR_EN for round-robin port arbitration instead of data-first.
module mem_arbiter #(
    parameter int BURST_LEN = 4,
    parameter int WORD_SIZE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_req,
    input  logic [WORD_SIZE-1:0] i_addr,
    output logic [WORD_SIZE-1:0] i_rdata,
    output logic                 i_valid,
    output logic                 i_done,
    input  logic                 d_rd,
    input  logic                 d_wr,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 d_valid,
    output logic                 d_done,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    input  logic                 mem_ready
);
    localparam int BW = $clog2(BURST_LEN);
    localparam logic [WORD_SIZE-1:0] ALIGN = ~(WORD_SIZE'(BURST_LEN - 1));
    typedef enum logic [2:0] {IDLE, I_FILL, D_FILL, D_WRITE, RESP} state_t;
    state_t state, state_nx;
    logic [BW-1:0] beat;
    logic owner_d;
    logic [WORD_SIZE-1:0] base, wdata;
    logic d_req, grant_d, fill, last_beat;
    assign d_req = d_rd | d_wr;
`ifdef MEM_ARBITER_RR_EN
    // last_d remembers which port was served last; the other port wins a tie
    logic last_d;
    assign grant_d = d_req & (~i_req | ~last_d);
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            last_d <= 1'b0;
        else if (state == IDLE && (d_req || i_req))
            last_d <= grant_d;
    end
`else
    assign grant_d = d_req;
`endif
    assign last_beat = beat == BW'(BURST_LEN - 1);
    assign fill = state == I_FILL || state == D_FILL;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:           state_nx = grant_d ? (d_wr ? D_WRITE : D_FILL) : (i_req ? I_FILL : IDLE);
            I_FILL, D_FILL: state_nx = mem_ready && last_beat ? RESP : state;
            D_WRITE:        state_nx = mem_ready ? RESP : state;
            default:        state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            beat    <= '0;
            owner_d <= 1'b0;
            base    <= '0;
            wdata   <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE) begin
                owner_d <= grant_d;
                base    <= grant_d ? (d_wr ? d_addr : d_addr & ALIGN) : i_addr & ALIGN;
                wdata   <= d_wdata;
                beat    <= '0;
            end else if (fill && mem_ready) begin
                // power-of-two burst: beat wraps back to 0 after the last word
                beat <= beat + 1'b1;
            end
        end
    end
    assign mem_read  = fill;
    assign mem_write = state == D_WRITE;
    assign mem_addr  = fill ? base + WORD_SIZE'(beat) : (mem_write ? base : '0);
    assign mem_wdata = mem_write ? wdata : '0;
    assign i_valid   = state == I_FILL && mem_ready;
    assign d_valid   = state == D_FILL && mem_ready;
    assign i_rdata   = i_valid ? mem_rdata : '0;
    assign d_rdata   = d_valid ? mem_rdata : '0;
    assign i_done    = state == RESP && !owner_d;
    assign d_done    = state == RESP && owner_d;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized scoreboard bench for mem_arbiter against a transaction-level model
module tb_mem_arbiter;
    localparam int BL = 4;
    localparam int W = 16;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic i_req = 1'b0, d_rd = 1'b0, d_wr = 1'b0, mem_ready = 1'b0;
    logic [W-1:0] i_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
    logic [W-1:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic i_valid, i_done, d_valid, d_done, mem_read, mem_write;
    always #5 clk = ~clk;
    mem_arbiter #(.BURST_LEN(BL), .WORD_SIZE(W)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid), .i_done(i_done),
        .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid), .d_done(d_done),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );
    // event kinds: 0 i beat, 1 d beat, 2 write accept, 3 i done, 4 d done
    typedef struct {int kind; logic [W-1:0] addr; logic [W-1:0] data;} ev_t;
    ev_t q[$];
    ev_t me;
    int checks = 0, failures = 0;
    int stall_n = 0;
    bit rnd_ready = 1'b0;
    bit last_d_m = 1'b0;
    bit exp_done_i = 1'b0, exp_done_d = 1'b0;
    int wr_run = 0, last_wr_len = 0, d_beats = 0;
    function automatic logic [W-1:0] f(input logic [W-1:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask
    // reads fetch the whole aligned line word by word; writes are one word
    function automatic void push_txn(input int k, input logic [W-1:0] a, input logic [W-1:0] wd);
        ev_t e;
        logic [W-1:0] b;
        if (k == 2) begin
            e.kind = 2; e.addr = a; e.data = wd; q.push_back(e);
            e.kind = 4; e.addr = '0; e.data = '0; q.push_back(e);
        end else begin
            b = a - (a % BL);
            for (int i = 0; i < BL; i++) begin
                e.kind = k; e.addr = b + W'(i); e.data = f(b + W'(i)); q.push_back(e);
            end
            e.kind = (k == 0) ? 3 : 4; e.addr = '0; e.data = '0; q.push_back(e);
        end
    endfunction
    always @(posedge clk) begin
        #2;
        if (stall_n > 0) begin
            mem_ready = 1'b0;
            stall_n--;
        end else
            mem_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        mem_rdata = mem_ready ? f(mem_addr) : W'($urandom);
    end
    always @(negedge clk) begin
        if (reset) begin
            exp_done_i = 1'b0;
            exp_done_d = 1'b0;
            wr_run = 0;
        end else begin
            chk("valid_excl", {31'b0, i_valid & d_valid}, 0);
            chk("cmd_excl", {31'b0, mem_read & mem_write}, 0);
            if (!i_valid) chk("i_rdata_zero", {16'b0, i_rdata}, 0);
            if (!d_valid) chk("d_rdata_zero", {16'b0, d_rdata}, 0);
            if (exp_done_i || exp_done_d) begin
                chk("i_done_latency", {31'b0, i_done}, {31'b0, exp_done_i});
                chk("d_done_latency", {31'b0, d_done}, {31'b0, exp_done_d});
            end
            exp_done_i = 1'b0;
            exp_done_d = 1'b0;
            if (i_valid || d_valid) begin
                if (q.size() == 0) chk("unexpected_beat", 1, 0);
                else begin
                    me = q.pop_front();
                    chk("beat_kind", me.kind, i_valid ? 0 : 1);
                    chk("beat_mem_read", {31'b0, mem_read}, 1);
                    chk("beat_addr", {16'b0, mem_addr}, {16'b0, me.addr});
                    chk("beat_rdata", {16'b0, i_valid ? i_rdata : d_rdata}, {16'b0, me.data});
                    if (d_valid) d_beats++;
                    if (q.size() > 0 && q[0].kind == 3) exp_done_i = 1'b1;
                    if (q.size() > 0 && q[0].kind == 4) exp_done_d = 1'b1;
                end
            end
            if (mem_read && !mem_ready && q.size() > 0)
                chk("stall_addr_held", {16'b0, mem_addr}, {16'b0, q[0].addr});
            if (mem_write) begin
                wr_run++;
                if (q.size() == 0) chk("unexpected_write", 1, 0);
                else begin
                    chk("write_kind", q[0].kind, 2);
                    chk("write_addr", {16'b0, mem_addr}, {16'b0, q[0].addr});
                    chk("write_data", {16'b0, mem_wdata}, {16'b0, q[0].data});
                    if (mem_ready) begin
                        me = q.pop_front();
                        exp_done_d = 1'b1;
                    end
                end
            end else if (wr_run > 0) begin
                last_wr_len = wr_run;
                wr_run = 0;
            end
            if (i_done || d_done) begin
                chk("resp_no_cmd", {31'b0, mem_read | mem_write}, 0);
                if (q.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    me = q.pop_front();
                    chk("done_kind", me.kind, i_done ? 3 : 4);
                end
            end
        end
    end
    task automatic recover();
        reset = 1'b1;
        i_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
        q.delete();
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk);
        #1;
    endtask
    // holds requests until each port's done, dropping them at the edge ending RESP
    task automatic run(input bit di, input bit dr, input bit dw, input logic [W-1:0] ia,
                       input logic [W-1:0] da, input logic [W-1:0] wd, input bit scr, output int lat);
        bit pi, pd, si, sd;
        int n;
        pi = di; pd = dr | dw;
        i_req = di; i_addr = ia; d_rd = dr; d_wr = dw; d_addr = da; d_wdata = wd;
        lat = -1;
        n = 0;
        while ((pi || pd) && n < 400) begin
            @(negedge clk);
            si = i_done; sd = d_done;
            if (si || sd) lat = n;
            @(posedge clk);
            #1;
            n++;
            if (si) begin pi = 1'b0; i_req = 1'b0; end
            if (sd) begin pd = 1'b0; d_rd = 1'b0; d_wr = 1'b0; end
            if (scr) begin i_addr = W'($urandom); d_addr = W'($urandom); d_wdata = W'($urandom); end
        end
        if (pi || pd) begin
            chk("timeout", 1, 0);
            recover();
        end
    endtask
    task automatic single(input int k, input logic [W-1:0] a, input logic [W-1:0] wd, input bit both, output int lat);
        push_txn(k, a, wd);
        last_d_m = k != 0;
        run(k == 0, k == 1 || (k == 2 && both), k == 2, a, a, wd, 1'b1, lat);
    endtask
    task automatic pair(input bit dr, input bit dw, input logic [W-1:0] ia, input logic [W-1:0] da, input logic [W-1:0] wd);
        bit df;
        int lat;
`ifdef MEM_ARBITER_RR_EN
        df = !last_d_m;
`else
        df = 1'b1;
`endif
        if (df) begin
            push_txn(dw ? 2 : 1, da, wd); push_txn(0, ia, '0); last_d_m = 1'b0;
        end else begin
            push_txn(0, ia, '0); push_txn(dw ? 2 : 1, da, wd); last_d_m = 1'b1;
        end
        run(1'b1, dr, dw, ia, da, wd, 1'b0, lat);
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end
    initial begin
        int lat, k, start;
        logic [W-1:0] a;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_read", {31'b0, mem_read}, 0);
        chk("rst_mem_write", {31'b0, mem_write}, 0);
        chk("rst_mem_addr", {16'b0, mem_addr}, 0);
        chk("rst_outs", {26'b0, i_valid, d_valid, i_done, d_done, |i_rdata, |d_rdata}, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        push_txn(0, 16'h0026, '0);
        last_d_m = 1'b0;
        run(1'b1, 1'b0, 1'b0, 16'h0026, '0, '0, 1'b0, lat);
        chk("i_fill_latency", lat, BL + 1);
        stall_n = 4;
        push_txn(2, 16'h0100, 16'hBEEF);
        last_d_m = 1'b1;
        run(1'b0, 1'b0, 1'b1, '0, 16'h0100, 16'hBEEF, 1'b0, lat);
        chk("write_latency", lat, 5);
        chk("write_hold_cycles", last_wr_len, 4);
        pair(1'b1, 1'b0, 16'h0210, 16'h0333, '0);
        pair(1'b1, 1'b0, 16'h0420, 16'h0555, '0);
        push_txn(2, 16'h0040, 16'h1234);
        last_d_m = 1'b1;
        run(1'b0, 1'b1, 1'b1, '0, 16'h0040, 16'h1234, 1'b0, lat);
        chk("rdwr_latency", lat, 2);
        push_txn(1, 16'h0777, '0);
        start = d_beats;
        d_rd = 1'b1; d_addr = 16'h0777;
        for (int i = 0; i < 50 && d_beats < start + 2; i++) @(negedge clk);
        chk("reset_test_beats", d_beats - start, 2);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("rst_mid_cmds", {30'b0, mem_read, mem_write}, 0);
        chk("rst_mid_addr", {16'b0, mem_addr}, 0);
        chk("rst_mid_outs", {28'b0, d_valid, d_done, |d_rdata, |mem_wdata}, 0);
        q.delete();
        last_d_m = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        push_txn(1, 16'h0777, '0);
        last_d_m = 1'b1;
        @(posedge clk);
        #1;
        chk("first_grant_after_reset", {31'b0, mem_read}, 1);
        run(1'b0, 1'b1, 1'b0, '0, 16'h0777, '0, 1'b0, lat);
        rnd_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 2);
            a = W'($urandom);
            single(k, a, W'($urandom), $urandom_range(0, 1) == 1, lat);
        end
        for (int i = 0; i < 15; i++) begin
            k = $urandom_range(0, 2);
            pair(k != 2, k != 0, W'($urandom), W'($urandom), W'($urandom));
        end
        repeat (5) @(posedge clk);
        chk("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
